// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM states, cause codes,
// register offsets (addr[4:2]) and pending/enable bit positions.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_TIMER = 2'b01;
  localparam logic [1:0] CAUSE_EXT   = 2'b10;
  localparam logic [1:0] CAUSE_SOFT  = 2'b11;

  localparam logic [2:0] REG_MTIME    = 3'd0;
  localparam logic [2:0] REG_MTIMECMP = 3'd1;
  localparam logic [2:0] REG_ENABLE   = 3'd2;
  localparam logic [2:0] REG_PENDING  = 3'd3;
  localparam logic [2:0] REG_SOFT     = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  localparam int unsigned BIT_TIMER = 0;
  localparam int unsigned BIT_EXT   = 1;
  localparam int unsigned BIT_SOFT  = 2;

  // Priority: external > timer > software.
  function automatic logic [1:0] pick_cause(input logic [2:0] active);
    logic [1:0] cause;
    cause = CAUSE_NONE;
    if (active[BIT_EXT])        cause = CAUSE_EXT;
    else if (active[BIT_TIMER]) cause = CAUSE_TIMER;
    else if (active[BIT_SOFT])  cause = CAUSE_SOFT;
    return cause;
  endfunction

endpackage

// File: rtl/irq_timer.sv
// Machine timer: free-running mtime, mtimecmp register, and the
// unsigned mtime >= mtimecmp comparator that forms the timer-pending level.
module irq_timer
  import irq_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mtime_we_i,
  input  logic               mtimecmp_we_i,
  input  logic [TIMER_W-1:0] wdata_i,
  output logic [TIMER_W-1:0] mtime_o,
  output logic [TIMER_W-1:0] mtimecmp_o,
  output logic               timer_pend_o
);

  logic [TIMER_W-1:0] mtime_q, mtime_d;
  logic [TIMER_W-1:0] mtimecmp_q, mtimecmp_d;

  // A software write to mtime overrides the increment in the same cycle.
  always_comb begin
    mtime_d    = mtime_we_i ? wdata_i : mtime_q + TIMER_W'(1);
    mtimecmp_d = mtimecmp_we_i ? wdata_i : mtimecmp_q;
  end

  // Timer registers; mtimecmp resets to all-ones so the timer starts quiet.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign mtime_o      = mtime_q;
  assign mtimecmp_o   = mtimecmp_q;
  assign timer_pend_o = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller feeding the core's 2-bit interrupt input.
// Optional build macro IRQ_EXT_SYNC_EN: adds a 2-flop synchronizer on ext_irq
// ahead of the rising-edge detector (external latency grows by two cycles).
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  input  logic        ext_irq,
  input  logic        ack,
  input  logic        mret_done,
  output logic [1:0]  interrupt
);

  logic [2:0]         sel;
  logic               wr_mtime, wr_mtimecmp, wr_enable, wr_pending, wr_soft;
  logic [TIMER_W-1:0] mtime, mtimecmp;
  logic               timer_pend;
  logic               ext_level, ext_rise;
  logic               ack_take;
  logic [2:0]         pend_vec, active;
  logic [31:0]        rd_val;

  irq_state_e  state_q;
  logic [1:0]  cause_q;
  logic [1:0]  irq_q;
  logic [2:0]  en_q, en_d;
  logic        ext_pend_q, ext_pend_d;
  logic        soft_pend_q, soft_pend_d;
  logic        ext_prev_q;
  logic [31:0] rdata_q;
  logic        unused_addr;

  assign sel         = addr[4:2];
  assign wr_mtime    = wr_en && (sel == REG_MTIME);
  assign wr_mtimecmp = wr_en && (sel == REG_MTIMECMP);
  assign wr_enable   = wr_en && (sel == REG_ENABLE);
  assign wr_pending  = wr_en && (sel == REG_PENDING);
  assign wr_soft     = wr_en && (sel == REG_SOFT);
  assign unused_addr = ^addr[1:0];

  irq_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk_i        (clk),
    .rst_ni       (rst),
    .mtime_we_i   (wr_mtime),
    .mtimecmp_we_i(wr_mtimecmp),
    .wdata_i      (TIMER_W'(wdata)),
    .mtime_o      (mtime),
    .mtimecmp_o   (mtimecmp),
    .timer_pend_o (timer_pend)
  );

`ifdef IRQ_EXT_SYNC_EN
  logic [1:0] ext_sync_q;

  // Two-stage synchronizer for an ext_irq from another clock domain.
  always_ff @(posedge clk) begin
    if (!rst) ext_sync_q <= '0;
    else      ext_sync_q <= {ext_sync_q[0], ext_irq};
  end

  assign ext_level = ext_sync_q[1];
`else
  assign ext_level = ext_irq;
`endif

  assign ext_rise = ext_level && !ext_prev_q;
  assign ack_take = ack && (state_q == ST_ASSERT);
  assign pend_vec = {soft_pend_q, ext_pend_q, timer_pend};
  assign active   = pend_vec & en_q;

  // Pending/enable next state: clears are applied first so a same-cycle set wins.
  always_comb begin
    en_d        = wr_enable ? wdata[2:0] : en_q;
    ext_pend_d  = ext_pend_q;
    soft_pend_d = soft_pend_q;
    if (wr_pending) begin
      if (wdata[BIT_EXT])  ext_pend_d  = 1'b0;
      if (wdata[BIT_SOFT]) soft_pend_d = 1'b0;
    end
    if (ack_take) begin
      if (cause_q == CAUSE_EXT)  ext_pend_d  = 1'b0;
      if (cause_q == CAUSE_SOFT) soft_pend_d = 1'b0;
    end
    if (ext_rise)              ext_pend_d  = 1'b1;
    if (wr_soft && wdata[0])   soft_pend_d = 1'b1;
  end

  // Enable, pending and edge-detector registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q        <= '0;
      ext_pend_q  <= 1'b0;
      soft_pend_q <= 1'b0;
      ext_prev_q  <= 1'b0;
    end else begin
      en_q        <= en_d;
      ext_pend_q  <= ext_pend_d;
      soft_pend_q <= soft_pend_d;
      ext_prev_q  <= ext_level;
    end
  end

  // Request FSM: latch a cause, hold it until ack, then wait for mret.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      irq_q   <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|active) begin
            cause_q <= pick_cause(active);
            irq_q   <= pick_cause(active);
            state_q <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (ack) begin
            irq_q   <= CAUSE_NONE;
            state_q <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (mret_done) state_q <= ST_IDLE;
        end
        default: begin
          irq_q   <= CAUSE_NONE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Register read multiplexer.
  always_comb begin
    rd_val = '0;
    case (sel)
      REG_MTIME:    rd_val = 32'(mtime);
      REG_MTIMECMP: rd_val = 32'(mtimecmp);
      REG_ENABLE:   rd_val = {29'b0, en_q};
      REG_PENDING:  rd_val = {29'b0, pend_vec};
      REG_STATUS:   rd_val = {28'b0, cause_q, state_q};
      default:      rd_val = '0;
    endcase
  end

  // Registered load data, zero in any cycle that does not follow a read.
  always_ff @(posedge clk) begin
    if (!rst)       rdata_q <= '0;
    else if (rd_en) rdata_q <= rd_val;
    else            rdata_q <= '0;
  end

  assign rdata     = rdata_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed vector table, a few
// latency sequences, and randomized traffic against a reference model.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0, ext_irq = 1'b0, ack = 1'b0, mret_done = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  interrupt;

  int checks = 0;
  int errors = 0;

`ifdef IRQ_EXT_SYNC_EN
  localparam int EXT_LAT = 4;
`else
  localparam int EXT_LAT = 2;
`endif

  irq_controller #(.TIMER_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .rd_en(rd_en), .rdata(rdata), .ext_irq(ext_irq), .ack(ack),
    .mret_done(mret_done), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rstn;
    bit          wr;
    bit          rd;
    logic [4:0]  a;
    logic [31:0] d;
    bit          ext;
    bit          ak;
    bit          mr;
    int unsigned rep;
    logic [31:0] exp_rd;
    logic [1:0]  exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic g(input bit rstn, input bit wr, input bit rd, input logic [4:0] a,
                   input logic [31:0] d, input bit ext, input bit ak, input bit mr,
                   input logic [31:0] er, input logic [1:0] ei);
    vec_t v;
    v = '{rstn, wr, rd, a, d, ext, ak, mr, 1, er, ei};
    tbl.push_back(v);
  endtask

  task automatic r(input logic [4:0] a, input logic [31:0] er, input logic [1:0] ei);
    g(1, 0, 1, a, 0, 0, 0, 0, er, ei);
  endtask

  task automatic w(input logic [4:0] a, input logic [31:0] d, input logic [1:0] ei);
    g(1, 1, 0, a, d, 0, 0, 0, 0, ei);
  endtask

  task automatic c(input bit ext, input bit ak, input bit mr, input int unsigned rep,
                   input logic [1:0] ei);
    vec_t v;
    v = '{1, 0, 0, 5'd0, 32'd0, ext, ak, mr, rep, 32'd0, ei};
    tbl.push_back(v);
  endtask

  task automatic drive(input bit rstn, input bit wr, input bit rd, input logic [4:0] a,
                       input logic [31:0] d, input bit ext, input bit ak, input bit mr);
    rst = rstn; wr_en = wr; rd_en = rd; addr = a; wdata = d;
    ext_irq = ext; ack = ak; mret_done = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model state, reset to the documented power-on values.
  logic [31:0] m_time, m_cmp;
  logic [2:0]  m_en;
  bit          m_pe, m_ps, m_ext_prev;
  int          m_phase;   // 0 waiting, 1 raised, 2 in handler
  int          m_cause;
  int          m_irq;

  task automatic model_reset();
    m_time = 0; m_cmp = 32'hFFFF_FFFF; m_en = 0; m_pe = 0; m_ps = 0;
    m_ext_prev = 0; m_phase = 0; m_cause = 0; m_irq = 0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input logic [4:0] a,
                            input logic [31:0] d, input bit ext, input bit ak, input bit mr,
                            output logic [1:0] e_irq, output logic [31:0] e_rd);
    bit          tp;
    int          reg_no;
    logic [31:0] rv;
    logic [2:0]  act;
    bit          npe, nps;
    tp     = (m_time >= m_cmp);
    reg_no = int'(a) / 4;
    case (reg_no)
      0: rv = m_time;
      1: rv = m_cmp;
      2: rv = 32'(m_en);
      3: rv = 32'(int'(m_ps) * 4 + int'(m_pe) * 2 + int'(tp));
      5: rv = 32'(m_cause * 4 + m_phase);
      default: rv = 0;
    endcase
    e_rd = rd ? rv : 32'd0;
    npe = m_pe; nps = m_ps;
    if (wr && reg_no == 3) begin
      if (d[1]) npe = 0;
      if (d[2]) nps = 0;
    end
    if (ak && m_phase == 1) begin
      if (m_cause == 2) npe = 0;
      if (m_cause == 3) nps = 0;
    end
    if (ext && !m_ext_prev) npe = 1;
    if (wr && reg_no == 4 && d[0]) nps = 1;
    if (m_phase == 0) begin
      act = m_en & {m_ps, m_pe, tp};
      if (act != 0) begin
        if (act[1])      m_cause = 2;
        else if (act[0]) m_cause = 1;
        else             m_cause = 3;
        m_irq = m_cause;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ak) begin
        m_phase = 2;
        m_irq = 0;
      end
    end else if (mr) begin
      m_phase = 0;
    end
    m_time = (wr && reg_no == 0) ? d : m_time + 32'd1;
    if (wr && reg_no == 1) m_cmp = d;
    if (wr && reg_no == 2) m_en = d[2:0];
    m_pe = npe; m_ps = nps; m_ext_prev = ext;
    e_irq = 2'(m_irq);
  endtask

  task automatic run_random(input int n);
    logic [1:0]  e_irq;
    logic [31:0] e_rd;
    for (int k = 0; k < n; k++) begin
      bit          wr, rd, ext, ak, mr;
      logic [4:0]  a;
      logic [31:0] d;
      wr  = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 2) == 0);
      a   = 5'($urandom_range(0, 31));
      d   = $urandom;
      ext = 1'($urandom_range(0, 1));
      ak  = ($urandom_range(0, 3) == 0);
      mr  = ($urandom_range(0, 3) == 0);
      if (wr && a[4:2] == 3'd0)
        d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : 32'($urandom_range(0, 300));
      if (wr && a[4:2] == 3'd1)
        d = m_time + 32'($urandom_range(0, 40));
      model_step(wr, rd, a, d, ext, ak, mr, e_irq, e_rd);
      drive(1, wr, rd, a, d, ext, ak, mr);
      tick();
      check($sformatf("rand%0d irq", k), 32'(interrupt), 32'(e_irq));
      check($sformatf("rand%0d rdata", k), rdata, e_rd);
    end
  endtask

  initial begin
    int n;
    bit found;

    // Reset and read-back of reset values.
    c(0, 0, 0, 1, 0);
    tbl.delete();
    r(0, 0, 0); r(4, 32'hFFFF_FFFF, 0); r(8, 0, 0); r(12, 0, 0);
    r(20, 0, 0); r(24, 0, 0); r(28, 0, 0);
    c(0, 0, 0, 1, 0);
    // Timer: cmp=20 raises cause 01 exactly at mtime 20.
    w(4, 20, 0); w(8, 1, 0); c(0, 0, 0, 10, 0); c(0, 0, 0, 1, 1);
    r(12, 1, 1); r(20, 5, 1); c(0, 1, 0, 1, 0); w(4, 1000, 0);
    c(0, 0, 1, 1, 0); c(0, 0, 0, 1, 0); r(20, 4, 0);
    // Priority: soft and ext together -> external first, then software.
    w(8, 7, 0); g(1, 1, 0, 16, 1, 1, 0, 0, 0, 0); c(0, 0, 0, 1, 2);
    c(0, 1, 0, 1, 0); c(0, 0, 1, 1, 0); c(0, 0, 0, 1, 3); r(12, 4, 3);
    // Hold: disabling and clearing do not retract; spurious mret ignored.
    w(8, 0, 3); w(12, 6, 3); c(0, 0, 1, 1, 3); c(0, 0, 0, 1, 3);
    c(0, 1, 0, 1, 0); r(20, 14, 0); c(0, 1, 0, 1, 0); c(0, 0, 1, 1, 0); r(12, 0, 0);
    // ack and new ext edge together; W1C and new ext edge together.
    w(8, 6, 0); c(1, 0, 0, 1, 0); c(0, 0, 0, 1, 2); c(1, 1, 0, 1, 0);
    g(1, 0, 1, 12, 0, 1, 0, 1, 2, 0); c(1, 0, 0, 1, 2); c(1, 1, 0, 1, 0); c(0, 0, 1, 1, 0);
    g(1, 1, 0, 12, 2, 1, 0, 0, 0, 0); c(1, 0, 0, 1, 2); c(1, 1, 0, 1, 0);
    c(0, 0, 1, 1, 0); c(0, 0, 0, 1, 0);
    // Wrap and write-over-increment.
    w(0, 32'hFFFF_FFFE, 0); c(0, 0, 0, 1, 0); r(0, 32'hFFFF_FFFF, 0); r(0, 0, 0);
    w(0, 32'h1234, 0); r(0, 32'h1234, 0); r(0, 32'h1235, 0); r(12, 1, 0);
    // Reset while in SERVICE with a soft request pending.
    w(8, 1, 0); c(0, 0, 0, 1, 1); c(0, 1, 0, 1, 0); w(16, 1, 0);
    g(0, 0, 1, 12, 0, 0, 0, 0, 0, 0);
    r(12, 0, 0); r(20, 0, 0); r(8, 0, 0); r(4, 32'hFFFF_FFFF, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check("reset irq", 32'(interrupt), 0);
    check("reset rdata", rdata, 0);

    foreach (tbl[i]) begin
      for (int unsigned k = 0; k < tbl[i].rep; k++) begin
        drive(tbl[i].rstn, tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d,
              tbl[i].ext, tbl[i].ak, tbl[i].mr);
        tick();
      end
      check($sformatf("row%0d irq", i), 32'(interrupt), 32'(tbl[i].exp_irq));
      check($sformatf("row%0d rdata", i), rdata, tbl[i].exp_rd);
    end

    // Timer latency with bounded wait, then re-raise while still pending.
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 4, 30, 0, 0, 0); tick();
    drive(1, 1, 0, 8, 1, 0, 0, 0); tick();
    found = 0; n = 2;
    for (int k = 2; k < 120; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
      n = k;
      if (interrupt != 2'b00) begin found = 1; break; end
    end
    check("timer found", 32'(found), 1);
    check("timer latency", n, 30);
    check("timer cause", 32'(interrupt), 1);
    drive(1, 0, 0, 0, 0, 0, 1, 0); tick();
    check("timer ack", 32'(interrupt), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1); tick();
    check("timer mret", 32'(interrupt), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    check("timer relevel", 32'(interrupt), 1);

    // External rising-edge latency with bounded wait.
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 8, 2, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    n = 0; found = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n = k;
      if (interrupt == 2'b10) begin found = 1; break; end
    end
    check("ext found", 32'(found), 1);
    check("ext latency", n, EXT_LAT);

    // Randomized traffic against the model from a fresh reset.
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    model_reset();
    run_random(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

- Memory-mapped interrupt source for the 3-stage RISC-V core.
- Drives the core's 2-bit `interrupt` input from three sources: a machine timer, one external line and a software trigger.
- Holds each request until the core's trap-taken acknowledge, then waits for the handler's `mret` before raising the next cause.
- Sits beside data memory on the core's load/store port, decoded by address.

## Interface
- `TIMER_W`, default 32: width of the `mtime` and `mtimecmp` registers.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low (`rst`=0 resets on the rising edge of `clk`).
- `addr`  in  5  byte offset; `addr[4:2]` selects the register.
- `wdata`  in  32  store data.
- `wr_en`  in  1  store strobe, one cycle per write.
- `rd_en`  in  1  load strobe.
- `rdata`  out  32  load data.
- `ext_irq`  in  1  external request, level input; captured on its rising edge.
- `ack`  in  1  trap-taken pulse from the core (its `epc_taken`).
- `mret_done`  in  1  `mret` committed in the core's memory/writeback stage.
- `interrupt`  out  2  cause code: 00 none, 01 timer, 10 external, 11 software.

## Operation
- Register map, selected by `addr[4:2]`:
  - 0 MTIME: read/write; increments by 1 every cycle.
  - 1 MTIMECMP: read/write.
  - 2 ENABLE: bits [2:0] = timer, external, software.
  - 3 PENDING: bits [2:0]; writing 1 clears the external (bit 1) and software (bit 2) bits. Bit 0 is read-only.
  - 4 SOFT: writing `wdata[0]`=1 sets software pending.
  - 5 STATUS: bits [1:0] = state, bits [3:2] = latched cause.
  - 6-7: reads return 0; writes are ignored.
- Timer pending is a level: `mtime >= mtimecmp` (unsigned). The handler clears it by rewriting MTIMECMP.
- External pending is set on a rising edge of `ext_irq`.
- Priority order: external > timer > software.
- FSM:
  - IDLE: if any `pending & enable` bit is set, latch the highest-priority cause and go to ASSERT.
  - ASSERT: `interrupt` = latched cause. On `ack`, clear the latched source's pending bit (external/software only) and go to SERVICE.
  - SERVICE: `interrupt`=00. On `mret_done`, go to IDLE.
- Once asserted, a cause is never retracted or replaced before `ack`, even if its enable or pending bit is cleared.
- `ack` outside ASSERT and `mret_done` outside SERVICE are ignored.
- Simultaneous events:
  - Software write to MTIME and the increment in the same cycle: the write wins.
  - W1C and a new set of the same pending bit in the same cycle: the set wins.
  - `ack` and a new event in the same cycle: the new event stays pending.
- `mtime` wraps from all-ones to 0.

## Timing
- Reset values: `mtime`=0, `mtimecmp`=all-ones, ENABLE=0, PENDING=0, state IDLE, `interrupt`=00, `rdata`=0.
- `interrupt` is registered. It becomes valid 1 cycle after `pending & enable` is true in IDLE.
- External path: `ext_irq` rising edge at cycle N sets pending at edge N+1; `interrupt` is valid at N+2.
- Writes take effect at the next clock edge.
- `rdata` is registered and valid the cycle after `rd_en`. It is 0 in any cycle not following a read.
- `ack` in ASSERT gives `interrupt`=00 on the next cycle.
- Reset asserted mid-operation returns the block to IDLE with `interrupt`=00 at that edge. Any in-flight cause is discarded.

## Configuration
- `IRQ_EXT_SYNC_EN` defined: `ext_irq` passes through a 2-flop synchronizer before edge detection. External latency becomes N+4.
- Not defined: `ext_irq` is sampled directly, as a same-clock-domain signal.

## Structure
- Package `irq_pkg`:
  - FSM state enum (IDLE, ASSERT, SERVICE);
  - cause code constants;
  - register offset constants;
  - pending/enable bit indices.
- Sub-module `irq_timer`: `mtime` counter, MTIMECMP register, write-wins update and comparator. Outputs the timer-pending level.

## Test plan
- Reset: `rst`=0 for 2 cycles → all registers read back their reset values; `interrupt`=00.
- Timer:
  - Stimulus: write MTIMECMP=20, ENABLE=001; at `mtime`≥20 → `interrupt`=01.
  - Stimulus: `ack` → next cycle 00.
  - Stimulus: rewrite MTIMECMP=1000, then `mret_done` → stays 00.
- Priority: ENABLE=111 with software and external pending in the same cycle → 10 first. After `ack` + `mret_done` → 11.
- Hold: a cause in ASSERT with ENABLE then written to 0 → `interrupt` stays at the cause until `ack`. A spurious `mret_done` in ASSERT is ignored.
- Mid-operation reset: reset in SERVICE → IDLE and 00; PENDING=0 after release.
- Wrap: MTIME=0xFFFF_FFFE → reads 0 two cycles later. A write to MTIME in the same cycle as the increment → the written value is held.
